// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx: oversampled SPI mode-0 slave that deserialises MSB-first words
// onto a valid/ready stream, with clear-to-send, frame markers and overrun flag.
module spi_pixel_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    input  logic              i_spi_cs_n,
    output logic              o_spi_cts,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eof,
    input  logic              i_fifo_almost_full,
    output logic              o_overrun,
    input  logic              i_clear_err
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_d, cs_d;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_W-2:0]      shreg;
    logic                   first_flag;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, cs_fall, cs_rise;
    logic                   shift_en, word_done, out_free;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_d;
    assign cs_fall   = !cs_s && cs_d;
    assign cs_rise   = cs_s && !cs_d;
    // a chip-select rise in the same cycle as an sclk rise discards that bit
    assign shift_en  = (state == SHIFT) && sclk_rise && !cs_rise;
    assign word_done = shift_en && (bit_cnt == CW'(DATA_W - 1));
    assign out_free  = !o_valid || i_ready;

    always_comb begin
        state_nx = (state == IDLE && cs_fall) ? SHIFT :
                   (state == SHIFT && cs_rise) ? IDLE : state;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            first_flag <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_overrun  <= 1'b0;
            o_spi_cts  <= 1'b0;
        end else begin
            state     <= state_nx;
            o_eof     <= (state == SHIFT) && cs_rise;
            o_spi_cts <= !i_fifo_almost_full && !(o_valid && !i_ready);
            if (state == IDLE && cs_fall) begin
                bit_cnt    <= '0;
                first_flag <= 1'b1;
            end else if (state == SHIFT && cs_rise) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[DATA_W-3:0], mosi_s};
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) first_flag <= 1'b0;
            end
            if (word_done && out_free) begin
                o_data  <= {shreg, mosi_s};
                o_valid <= 1'b1;
                o_sof   <= first_flag;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (word_done && !out_free) o_overrun <= 1'b1;
            else if (i_clear_err) o_overrun <= 1'b0;
        end
    end
endmodule
